// File: rtl/qpsk_csr_axil_slave.sv
// ---------------------------------------------------------------------------
// qpsk_csr_axil_slave
//
// AXI4-Lite responder holding the QPSK datapath control registers.
// Four 32-bit read/write registers (REG0..REG3 at 0x00..0x0C) drive the
// modulator/demodulator fabric. Each register raises a one-cycle pulse on
// reg_wr_pulse when a write to it commits. One outstanding write and one
// outstanding read are supported.
//
// Optional feature (macro QPSK_CSR_STATUS_EN):
//   defined   - 0x10 is a read-only STATUS register returning status_in.
//               Writes to it get SLVERR and produce no pulse.
//   undefined - 0x10 is unmapped (SLVERR) and status_in is unused.
//
// Ports
//   s00_axi_aclk / s00_axi_areset  clock; asynchronous active-high reset
//   s00_axi_aw*                    write address channel (awprot ignored)
//   s00_axi_w*                     write data channel, per-byte wstrb
//   s00_axi_b*                     write response: 00 OKAY, 10 SLVERR
//   s00_axi_ar*                    read address channel (arprot ignored)
//   s00_axi_r*                     read data / response
//   reg_out                        {REG3,REG2,REG1,REG0}
//   reg_wr_pulse                   bit k high one cycle after REGk commits
//   status_in                      datapath status (macro builds only)
// ---------------------------------------------------------------------------
module qpsk_csr_axil_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] REG_RESET_VAL      = 32'h0
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [3:0]                      reg_wr_pulse,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   status_in
);

  localparam int         DW          = C_S_AXI_DATA_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] regs_d [4];

  logic          aw_held_q, aw_held_d;
  logic [2:0]    awidx_q, awidx_d;
  logic          w_held_q, w_held_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;

  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          arready_q, arready_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [3:0]    pulse_q, pulse_d;

  logic          aw_hs, w_hs, ar_hs, commit;
  logic [DW-1:0] byte_mask;

  logic          unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                           s00_axi_araddr[1:0], status_in};

  // -------------------------------------------------------------------------
  // Write path
  // -------------------------------------------------------------------------
  always_comb begin
    aw_hs     = s00_axi_awvalid & awready_q;
    w_hs      = s00_axi_wvalid & wready_q;
    aw_held_d = aw_held_q;
    awidx_d   = awidx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    regs_d    = regs_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    pulse_d   = '0;
    commit    = 1'b0;
    byte_mask = '0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awidx_d   = s00_axi_awaddr[4:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s00_axi_wdata;
      wstrb_d  = s00_axi_wstrb;
    end
    if (bvalid_q && s00_axi_bready) begin
      bvalid_d = 1'b0;
    end

    // A handshake on this edge already counts as held, so the commit lands on
    // the edge of the later (or simultaneous) AW/W handshake.
    commit = aw_held_d & w_held_d;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      byte_mask = {{8{wstrb_d[3]}}, {8{wstrb_d[2]}}, {8{wstrb_d[1]}}, {8{wstrb_d[0]}}};
      if (awidx_d < 3'd4) begin
        regs_d[awidx_d[1:0]] = (regs_q[awidx_d[1:0]] & ~byte_mask) | (wdata_d & byte_mask);
        pulse_d[awidx_d[1:0]] = 1'b1;
        bresp_d = RESP_OKAY;
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end

    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d & ~bvalid_d;
  end

  // -------------------------------------------------------------------------
  // Read path: data comes from pre-edge register values, so a same-edge write
  // commit to the same register is not visible in this read.
  // -------------------------------------------------------------------------
  always_comb begin
    ar_hs    = s00_axi_arvalid & arready_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_SLVERR;
      case (s00_axi_araddr[4:2])
        3'd0, 3'd1, 3'd2, 3'd3: begin
          rdata_d = regs_q[s00_axi_araddr[3:2]];
          rresp_d = RESP_OKAY;
        end
`ifdef QPSK_CSR_STATUS_EN
        3'd4: begin
          rdata_d = status_in;
          rresp_d = RESP_OKAY;
        end
`endif
        default: begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end
      endcase
    end

    arready_d = ~rvalid_d;
  end

  // -------------------------------------------------------------------------
  // State registers. Readies reset low and rise on the first edge after reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      regs_q    <= '{default: REG_RESET_VAL};
      aw_held_q <= 1'b0;
      awidx_q   <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      pulse_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      aw_held_q <= aw_held_d;
      awidx_q   <= awidx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      pulse_q   <= pulse_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;
  assign reg_wr_pulse    = pulse_q;
  assign reg_out         = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

endmodule
